battleship_board_ctrl: RTL and testbench



---
 rtl/battleship_pkg.sv | 25 ++
 rtl/battleship_board_mem.sv | 38 +++
 rtl/battleship_board_ctrl.sv | 139 +++++++++++++
 tb/tb_battleship_board_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// battleship_pkg: shared cell/result encodings, FSM states and board geometry for battleship_board_ctrl
package battleship_pkg;
  localparam int GRID_N = 10;
  localparam int CELL_W = 2;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] MAX_SHIP_CELLS = 5'd17;
  localparam logic [3:0] LAST_IDX = 4'(GRID_N - 1);
  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [GRID_N-1:0][GRID_N*CELL_W-1:0] board_t;
  localparam cell_t CELL_WATER = 2'b00;
  localparam cell_t CELL_SHIP = 2'b01;
  localparam cell_t CELL_MISS = 2'b10;
  localparam cell_t CELL_HIT = 2'b11;
  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT = 2'b10;
  localparam logic [1:0] RES_REJ = 2'b11;
  typedef enum logic [2:0] {ST_SETUP, ST_PLAY, ST_RESOLVE, ST_WRITE, ST_DONE} state_e;
  function automatic logic on_grid(input logic [3:0] r, input logic [3:0] c);
    return (r <= LAST_IDX) && (c <= LAST_IDX);
  endfunction
  // column 0 sits in the top bits of a row vector
  function automatic int col_lsb(input logic [3:0] c);
    return (c <= LAST_IDX) ? CELL_W * (GRID_N - 1 - int'(c)) : 0;
  endfunction
endpackage

// File: rtl/battleship_board_mem.sv
// battleship_board_mem: one 10x10 board with a read port, a write port and a live ship-cell counter
module battleship_board_mem
  import battleship_pkg::*;
(
  input  logic             clock50,
  input  logic             reset_n,
  input  logic [3:0]       rd_row_i,
  input  logic [3:0]       rd_col_i,
  output cell_t            rd_data_o,
  input  logic             we_i,
  input  logic [3:0]       wr_row_i,
  input  logic [3:0]       wr_col_i,
  input  cell_t            wr_data_i,
  output logic [CNT_W-1:0] cnt_o,
  output board_t           board_o
);
  board_t board_q, board_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign rd_data_o = on_grid(rd_row_i, rd_col_i) ? board_q[rd_row_i][col_lsb(rd_col_i) +: CELL_W] : CELL_WATER;
  assign cnt_o = cnt_q;
  assign board_o = board_q;
  // placements add a ship cell, hits remove one
  always_comb begin
    board_d = board_q;
    if (we_i) board_d[wr_row_i][col_lsb(wr_col_i) +: CELL_W] = wr_data_i;
    cnt_d = (we_i && wr_data_i == CELL_SHIP) ? cnt_q + CNT_W'(1) :
            (we_i && wr_data_i == CELL_HIT) ? cnt_q - CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      board_q <= '0;
      cnt_q <= '0;
    end else begin
      board_q <= board_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/battleship_board_ctrl.sv
// battleship_board_ctrl: two-player board placement, shot resolution, turn/win tracking and display rows.
// Define BOARD_FOG_EN to hide un-hit ship cells on the display until the game is over.
module battleship_board_ctrl
  import battleship_pkg::*;
(
  input  logic        clock50,
  input  logic        reset_n,
  input  logic        place_valid,
  input  logic        place_player,
  input  logic [3:0]  place_row,
  input  logic [3:0]  place_col,
  input  logic        start,
  input  logic        fire_valid,
  output logic        fire_ready,
  input  logic [3:0]  fire_row,
  input  logic [3:0]  fire_col,
  output logic        shot_done,
  output logic [1:0]  shot_result,
  output logic [19:0] A,
  output logic [19:0] B,
  output logic [19:0] C,
  output logic [19:0] D,
  output logic [19:0] E,
  output logic [19:0] F,
  output logic [19:0] G,
  output logic [19:0] H,
  output logic [19:0] I,
  output logic [19:0] J,
  output logic        playerTurn,
  output logic        game_over,
  output logic        winner
);
  state_e state_q, state_d;
  logic turn_q, turn_d, done_q, done_d, over_q, over_d, win_q, win_d;
  logic [3:0] frow_q, frow_d, fcol_q, fcol_d;
  logic [1:0] res_q, res_d;
  board_t disp_q, disp_d;
  board_t board [2];
  cell_t [1:0] rd;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0] we;
  logic [3:0] a_row, a_col;
  cell_t tgt, wdata;
  logic place_ok, shot_ok, hit;
  // one address serves both ports: placement coordinates in SETUP, the latched shot otherwise
  assign a_row = (state_q == ST_SETUP) ? place_row : frow_q;
  assign a_col = (state_q == ST_SETUP) ? place_col : fcol_q;
  assign tgt = rd[~turn_q];
  assign place_ok = state_q == ST_SETUP && place_valid && on_grid(place_row, place_col) &&
                    rd[place_player] == CELL_WATER && cnt[place_player] < MAX_SHIP_CELLS;
  assign shot_ok = state_q == ST_RESOLVE && on_grid(frow_q, fcol_q) && (tgt == CELL_WATER || tgt == CELL_SHIP);
  assign hit = tgt == CELL_SHIP;
  assign wdata = (state_q == ST_SETUP) ? CELL_SHIP : hit ? CELL_HIT : CELL_MISS;
  for (genvar p = 0; p < 2; p++) begin : g_mem
    assign we[p] = (place_ok && place_player == 1'(p)) || (shot_ok && turn_q != 1'(p));
    battleship_board_mem u_mem (
      .clock50   (clock50),
      .reset_n   (reset_n),
      .rd_row_i  (a_row),
      .rd_col_i  (a_col),
      .rd_data_o (rd[p]),
      .we_i      (we[p]),
      .wr_row_i  (a_row),
      .wr_col_i  (a_col),
      .wr_data_i (wdata),
      .cnt_o     (cnt[p]),
      .board_o   (board[p])
    );
  end
  // the shot's outcome, turn change and cell write all land on the RESOLVE->WRITE edge
  always_comb begin
    state_d = state_q;
    turn_d = turn_q;
    done_d = 1'b0;
    res_d = res_q;
    over_d = over_q;
    win_d = win_q;
    frow_d = frow_q;
    fcol_d = fcol_q;
    case (state_q)
      ST_SETUP: if (start && cnt[0] != '0 && cnt[1] != '0) state_d = ST_PLAY;
      ST_PLAY: if (fire_valid) begin
        frow_d = fire_row;
        fcol_d = fire_col;
        state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        done_d = 1'b1;
        state_d = ST_WRITE;
        res_d = !shot_ok ? RES_REJ : hit ? RES_HIT : RES_MISS;
        if (shot_ok && hit && cnt[~turn_q] == CNT_W'(1)) begin
          over_d = 1'b1;
          win_d = turn_q;
        end else if (shot_ok) turn_d = ~turn_q;
      end
      ST_WRITE: state_d = over_q ? ST_DONE : ST_PLAY;
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    disp_d = board[~turn_q];
`ifdef BOARD_FOG_EN
    for (int r = 0; r < GRID_N; r++)
      for (int c = 0; c < GRID_N; c++)
        if (state_q != ST_DONE && disp_d[r][CELL_W*c +: CELL_W] == CELL_SHIP) disp_d[r][CELL_W*c +: CELL_W] = CELL_WATER;
`endif
  end
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SETUP;
      turn_q <= 1'b0;
      done_q <= 1'b0;
      res_q <= '0;
      over_q <= 1'b0;
      win_q <= 1'b0;
      frow_q <= '0;
      fcol_q <= '0;
      disp_q <= '0;
    end else begin
      state_q <= state_d;
      turn_q <= turn_d;
      done_q <= done_d;
      res_q <= res_d;
      over_q <= over_d;
      win_q <= win_d;
      frow_q <= frow_d;
      fcol_q <= fcol_d;
      disp_q <= disp_d;
    end
  end
  assign fire_ready = state_q == ST_PLAY;
  assign shot_done = done_q;
  assign shot_result = res_q;
  assign playerTurn = turn_q;
  assign game_over = over_q;
  assign winner = win_q;
  assign {A, B, C, D, E} = {disp_q[0], disp_q[1], disp_q[2], disp_q[3], disp_q[4]};
  assign {F, G, H, I, J} = {disp_q[5], disp_q[6], disp_q[7], disp_q[8], disp_q[9]};
endmodule

// File: tb/tb_battleship_board_ctrl.sv
// tb_battleship_board_ctrl: table-driven placements plus scoreboarded shots against a reference board model
module tb_battleship_board_ctrl;
  logic clock50 = 1'b0, reset_n = 1'b0;
  logic place_valid = 1'b0, place_player = 1'b0, start = 1'b0, fire_valid = 1'b0;
  logic [3:0] place_row = '0, place_col = '0, fire_row = '0, fire_col = '0;
  logic fire_ready, shot_done, playerTurn, game_over, winner;
  logic [1:0] shot_result;
  logic [19:0] A, B, C, D, E, F, G, H, I, J;
  int total = 0, bad = 0;
  logic [1:0] mb [2][10][10];
  int mcnt [2];
  logic mturn, mover, mwin;
  logic [1:0] expq [$];
  typedef struct {logic p; int r; int c; bit ok;} place_t;
  place_t tbl [7];

  always #5 clock50 = ~clock50;

  battleship_board_ctrl dut (
    .clock50(clock50), .reset_n(reset_n),
    .place_valid(place_valid), .place_player(place_player), .place_row(place_row), .place_col(place_col),
    .start(start), .fire_valid(fire_valid), .fire_ready(fire_ready), .fire_row(fire_row), .fire_col(fire_col),
    .shot_done(shot_done), .shot_result(shot_result),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .I(I), .J(J),
    .playerTurn(playerTurn), .game_over(game_over), .winner(winner)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] exp_disp();
    logic [199:0] v;
    logic [1:0] cl;
    int t;
    v = '0;
    t = mturn ? 0 : 1;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        cl = mb[t][r][c];
`ifdef BOARD_FOG_EN
        if (!mover && cl == 2'b01) cl = 2'b00;
`endif
        v[199-20*r-2*c -: 2] = cl;
      end
    return v;
  endfunction

  task automatic chk_disp(input string name);
    chk(name, {A, B, C, D, E, F, G, H, I, J}, exp_disp());
  endtask

  task automatic clear_model();
    foreach (mb[p, r, c]) mb[p][r][c] = 2'b00;
    mcnt[0] = 0;
    mcnt[1] = 0;
    mturn = 0;
    mover = 0;
    mwin = 0;
    expq.delete();
  endtask

  task automatic do_reset();
    reset_n = 0;
    place_valid = 0;
    start = 0;
    fire_valid = 0;
    repeat (2) @(posedge clock50);
    #1;
    clear_model();
    chk("rst_turn", playerTurn, 0);
    chk("rst_ready", fire_ready, 0);
    chk("rst_done", shot_done, 0);
    chk("rst_result", shot_result, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk_disp("rst_disp");
    reset_n = 1;
  endtask

  task automatic place(input logic p, input int r, input int c, input bit ok);
    place_player = p;
    place_row = 4'(r);
    place_col = 4'(c);
    place_valid = 1;
    @(posedge clock50);
    #1;
    place_valid = 0;
    if (ok) begin
      mb[p][r][c] = 2'b01;
      mcnt[p]++;
    end
    @(posedge clock50);
    #1;
    chk_disp($sformatf("place_disp_p%0d_%0d_%0d", p, r, c));
  endtask

  task automatic do_start(input bit exp_ready);
    start = 1;
    @(posedge clock50);
    #1;
    start = 0;
    chk("start_ready", fire_ready, exp_ready);
  endtask

  task automatic fire(input int r, input int c);
    int t, k, lat;
    logic [1:0] cl, er, got;
    t = mturn ? 0 : 1;
    fire_row = 4'(r);
    fire_col = 4'(c);
    fire_valid = 1;
    if (mover) begin
      repeat (3) begin
        @(posedge clock50);
        #1;
        chk("over_ready", fire_ready, 0);
        chk("over_shot_done", shot_done, 0);
      end
      fire_valid = 0;
      return;
    end
    if (r <= 9 && c <= 9) cl = mb[t][r][c];
    else cl = 2'b11;
    er = cl[1] ? 2'b11 : cl[0] ? 2'b10 : 2'b01;
    k = 0;
    while (!fire_ready && k < 20) begin
      @(posedge clock50);
      #1;
      k++;
    end
    chk("fire_ready", fire_ready, 1);
    @(posedge clock50);
    #1;
    fire_valid = 0;
    expq.push_back(er);
    lat = 1;
    while (!shot_done && lat < 10) begin
      @(posedge clock50);
      #1;
      lat++;
    end
    chk($sformatf("shot_latency_%0d_%0d", r, c), lat, 2);
    got = expq.pop_front();
    chk($sformatf("shot_result_%0d_%0d", r, c), shot_result, got);
    if (er == 2'b10) begin
      mb[t][r][c] = 2'b11;
      mcnt[t]--;
      if (mcnt[t] == 0) begin
        mover = 1;
        mwin = mturn;
      end else mturn = ~mturn;
    end else if (er == 2'b01) begin
      mb[t][r][c] = 2'b10;
      mturn = ~mturn;
    end
    chk("turn_after_shot", playerTurn, mturn);
    chk("game_over", game_over, mover);
    chk("winner", winner, mwin);
    @(posedge clock50);
    #1;
    chk("ready_after_shot", fire_ready, !mover);
    if (mover) begin
      @(posedge clock50);
      #1;
    end
    chk_disp($sformatf("disp_after_%0d_%0d", r, c));
  endtask

  initial begin
    tbl[0] = '{1'b0, 2, 3, 1'b1};
    tbl[1] = '{1'b0, 2, 3, 1'b0};
    tbl[2] = '{1'b0, 2, 10, 1'b0};
    tbl[3] = '{1'b0, 12, 0, 1'b0};
    tbl[4] = '{1'b1, 9, 9, 1'b1};
    tbl[5] = '{1'b1, 9, 9, 1'b0};
    tbl[6] = '{1'b1, 5, 5, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) place(tbl[i].p, tbl[i].r, tbl[i].c, tbl[i].ok);
    do_start(0);
    for (int i = 4; i < 7; i++) place(tbl[i].p, tbl[i].r, tbl[i].c, tbl[i].ok);
    do_start(1);
    chk("play_turn", playerTurn, 0);
    chk("play_A", A, 20'h00000);
    chk_disp("play_disp");
    fire(4, 4);
    fire(4, 4);
    chk("E_miss_cell", E[11:10], 2'b10);
    fire(4, 4);
    fire(12, 0);
    fire(9, 9);
    fire(0, 0);
    fire(5, 5);
    chk("s1_winner_p1", winner, 0);
    fire(1, 1);
    place(0, 7, 7, 0);
    do_reset();
    place(0, 0, 0, 1);
    place(1, 9, 9, 1);
    do_start(1);
    chk("s2_A", A, 20'h00000);
    fire(9, 9);
    chk("s2_J_hit", J[1:0], 2'b11);
    chk("s2_over", game_over, 1);
    do_reset();
    place(0, 0, 0, 1);
    place(1, 9, 9, 1);
    place(1, 1, 1, 1);
    do_start(1);
    fire_row = 4'd9;
    fire_col = 4'd9;
    fire_valid = 1;
    chk("s3_ready", fire_ready, 1);
    @(posedge clock50);
    #1;
    fire_valid = 0;
    reset_n = 0;
    #1;
    clear_model();
    chk("s3_rst_turn", playerTurn, 0);
    chk("s3_rst_ready", fire_ready, 0);
    chk("s3_rst_done", shot_done, 0);
    chk("s3_rst_result", shot_result, 0);
    chk("s3_rst_over", game_over, 0);
    chk("s3_rst_winner", winner, 0);
    chk_disp("s3_rst_disp");
    repeat (2) @(posedge clock50);
    #1;
    reset_n = 1;
    repeat (3) begin
      @(posedge clock50);
      #1;
      chk("s3_no_shot", shot_done, 0);
    end
    chk("s3_ready_setup", fire_ready, 0);
    chk_disp("s3_disp_clear");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
